gf_inv_4_pipe: RTL and testbench

Pipelined, flow-controlled GF(2^4) inverter for the compact tower-field S-box datapath. It uses the normal basis [Z^4, Z] over GF(2^2) with basis [W^2, W]. It sits directly upstream of the GF(2^2) multiply-and-scale stage: it emits the inverse halves together with their shared-factor bits, so the downstream shared-factor multipliers consume them without recomputation. A sideband tag travels with each operand, so the surrounding S-box controller can track rounds or byte lanes.

---
 rtl/gf_inv_4_pipe.sv | 155 +++++++++++++++
 tb/tb_gf_inv_4_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf_inv_4_pipe.sv
// Two-stage GF(2^4) inverter (normal basis [Z^4, Z] over GF(2^2), basis [W^2, W]) with valid/ready flow control.
// Define GF_INV4_SKID_EN to add a one-entry skid buffer so in_ready comes straight from a flop.
module gf_inv_4_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [1:0]       out_sum,
  output logic             out_ab,
  output logic             out_cd,
  output logic [TAG_W-1:0] out_tag
);

  // GF(2^2) product in normal basis: W*W = W^2, W^2*W^2 = W, W*W^2 = 1.
  function automatic logic [1:0] gf2_mul(input logic [1:0] x, input logic [1:0] y);
    logic m;
    m = (x[1] & y[0]) ^ (x[0] & y[1]);
    return {(x[0] & y[0]) ^ m, (x[1] & y[1]) ^ m};
  endfunction

  function automatic logic [1:0] gf2_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] gf2_scale_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  logic             s1_valid_reg;
  logic [1:0]       s1_a_reg;
  logic [1:0]       s1_b_reg;
  logic [1:0]       s1_e_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic [3:0]       out_data_reg;
  logic [1:0]       out_sum_reg;
  logic             out_ab_reg;
  logic             out_cd_reg;
  logic [TAG_W-1:0] out_tag_reg;

  logic             s2_adv;
  logic             s1_adv;

  logic             s1_src_valid;
  logic [3:0]       s1_src_data;
  logic [TAG_W-1:0] s1_src_tag;

  assign s2_adv = ~s2_valid_reg | out_ready;
  assign s1_adv = ~s1_valid_reg | s2_adv;

`ifdef GF_INV4_SKID_EN
  logic             skid_valid_reg;
  logic [3:0]       skid_data_reg;
  logic [TAG_W-1:0] skid_tag_reg;
  logic             accept;

  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & ~skid_valid_reg;

  // A parked operand always goes ahead of anything newer.
  assign s1_src_valid = skid_valid_reg | accept;
  assign s1_src_data  = skid_valid_reg ? skid_data_reg : in_data;
  assign s1_src_tag   = skid_valid_reg ? skid_tag_reg : in_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_tag_reg   <= '0;
    end else if (skid_valid_reg) begin
      if (s1_adv) skid_valid_reg <= 1'b0;
    end else if (accept && !s1_adv) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= in_data;
      skid_tag_reg   <= in_tag;
    end
  end
`else
  assign in_ready     = s1_adv;
  assign s1_src_valid = in_valid;
  assign s1_src_data  = in_data;
  assign s1_src_tag   = in_tag;
`endif

  logic [1:0] s1_a;
  logic [1:0] s1_b;
  logic [1:0] s1_d;
  logic [1:0] s1_e;

  assign s1_a = s1_src_data[3:2];
  assign s1_b = s1_src_data[1:0];
  assign s1_d = gf2_scale_n(gf2_sq(s1_a ^ s1_b)) ^ gf2_mul(s1_a, s1_b);
  assign s1_e = gf2_sq(s1_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_e_reg     <= '0;
      s1_tag_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= s1_src_valid;
      if (s1_src_valid) begin
        s1_a_reg   <= s1_a;
        s1_b_reg   <= s1_b;
        s1_e_reg   <= s1_e;
        s1_tag_reg <= s1_src_tag;
      end
    end
  end

  logic [1:0] s2_p;
  logic [1:0] s2_q;

  assign s2_p = gf2_mul(s1_e_reg, s1_b_reg);
  assign s2_q = gf2_mul(s1_e_reg, s1_a_reg);

  // Output registers only change when a real result moves in, so bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      out_data_reg <= '0;
      out_sum_reg  <= '0;
      out_ab_reg   <= 1'b0;
      out_cd_reg   <= 1'b0;
      out_tag_reg  <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= {s2_p, s2_q};
        out_sum_reg  <= s2_p ^ s2_q;
        out_ab_reg   <= s2_p[1] ^ s2_p[0];
        out_cd_reg   <= s2_q[1] ^ s2_q[0];
        out_tag_reg  <= s1_tag_reg;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sum   = out_sum_reg;
  assign out_ab    = out_ab_reg;
  assign out_cd    = out_cd_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_gf_inv_4_pipe.sv
// Self-checking bench for gf_inv_4_pipe: fixed vectors, streaming, stall, reset and random flow control.
module tb_gf_inv_4_pipe;
  localparam int TAG_W  = 4;
  localparam int SNAP_W = 9 + TAG_W;
`ifdef GF_INV4_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [1:0]       out_sum;
  logic             out_ab;
  logic             out_cd;
  logic [TAG_W-1:0] out_tag;

  gf_inv_4_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sum(out_sum), .out_ab(out_ab), .out_cd(out_cd), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       d;
    logic [TAG_W-1:0] t;
  } sb_t;

  typedef struct {
    logic [3:0] din;
    logic [3:0] dout;
    logic [1:0] sum;
    logic       ab;
    logic       cd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int last_in_cyc = 0;
  int last_out_cyc = 0;
  logic got_out = 1'b0;
  logic [3:0] last_data;
  logic [1:0] last_sum;
  logic last_ab, last_cd;
  logic [TAG_W-1:0] last_tag;
  logic hold_chk = 1'b0;
  logic [SNAP_W-1:0] hold_snap;
  sb_t sb[$];
  vec_t vecs[8];

  // GF(2^2) via discrete logs: 11 = W^0, 01 = W^1, 10 = W^2.
  function automatic int gf2_log(input logic [1:0] x);
    if (x == 2'b11) return 0;
    if (x == 2'b01) return 1;
    return 2;
  endfunction

  function automatic logic [1:0] gf2_mul_ref(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    case ((gf2_log(x) + gf2_log(y)) % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // (aZ^4+bZ)(pZ^4+qZ) with Z^2+Z+N=0: cross terms collapse to N(a+b)(p+q) on both coordinates.
  function automatic logic [3:0] gf4_mul_ref(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] t;
    t = gf2_mul_ref(2'b10, gf2_mul_ref(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {gf2_mul_ref(x[3:2], y[3:2]) ^ t, gf2_mul_ref(x[1:0], y[1:0]) ^ t};
  endfunction

  function automatic logic [3:0] gf4_inv_ref(input logic [3:0] x);
    for (int y = 1; y < 16; y++)
      if (gf4_mul_ref(x, 4'(y)) == 4'hF) return 4'(y);
    return 4'h0;
  endfunction

  task automatic step(input logic v, input logic [3:0] d, input logic [TAG_W-1:0] t, input logic r);
    sb_t e;
    logic [3:0] inv;
    logic [1:0] p, q;
    @(negedge clk);
    if (hold_chk) begin
      checks++;
      if ({out_valid, out_data, out_sum, out_ab, out_cd, out_tag} != hold_snap) begin
        errors++;
        $display("FAIL stall_hold: got %0h, required %0h", {out_valid, out_data, out_sum, out_ab, out_cd, out_tag}, hold_snap);
      end
    end
    in_valid = v; in_data = d; in_tag = t; out_ready = r;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      got_out = 1'b1;
      last_data = out_data; last_sum = out_sum; last_ab = out_ab; last_cd = out_cd; last_tag = out_tag;
      last_out_cyc = cyc;
      n_out++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=%0h tag=%0h, required no output", out_data, out_tag);
      end else begin
        e = sb.pop_front();
        inv = gf4_inv_ref(e.d);
        p = inv[3:2]; q = inv[1:0];
        if ({out_data, out_sum, out_ab, out_cd, out_tag} != {inv, p ^ q, ^p, ^q, e.t}) begin
          errors++;
          $display("FAIL result din=%0h: got data=%0h sum=%0h ab=%0b cd=%0b tag=%0h, required data=%0h sum=%0h ab=%0b cd=%0b tag=%0h",
                   e.d, out_data, out_sum, out_ab, out_cd, out_tag, inv, p ^ q, ^p, ^q, e.t);
        end
        if (e.d != 4'h0) begin
          checks++;
          if (gf4_mul_ref(e.d, out_data) != 4'hF) begin
            errors++;
            $display("FAIL inverse_product din=%0h: got x*out=%0h, required f", e.d, gf4_mul_ref(e.d, out_data));
          end
        end
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back('{d: d, t: t});
      last_in_cyc = cyc;
      n_in++;
    end
    hold_chk  = out_valid & ~out_ready;
    hold_snap = {out_valid, out_data, out_sum, out_ab, out_cd, out_tag};
    cyc++;
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int n0, c0, acc;
    vecs[0] = '{4'h0, 4'h0, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{4'hF, 4'hF, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{4'h1, 4'hC, 2'b11, 1'b0, 1'b0};
    vecs[3] = '{4'h4, 4'h3, 2'b11, 1'b0, 1'b0};
    vecs[4] = '{4'h5, 4'hA, 2'b00, 1'b1, 1'b1};
    vecs[5] = '{4'hA, 4'h5, 2'b00, 1'b1, 1'b1};
    vecs[6] = '{4'h3, 4'h4, 2'b01, 1'b1, 1'b0};
    vecs[7] = '{4'hC, 4'h1, 2'b01, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_outputs", int'({out_data, out_sum, out_ab, out_cd, out_tag}), 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", int'(in_ready), 1);

    // Fixed vectors, one operand at a time, with latency check.
    for (int i = 0; i < 8; i++) begin
      got_out = 1'b0;
      step(1'b1, vecs[i].din, TAG_W'(i + 1), 1'b1);
      for (int k = 0; k < 8 && !got_out; k++) step(1'b0, 4'h0, '0, 1'b1);
      if (!got_out) begin
        errors++; checks++;
        $display("FAIL vec%0d_timeout: got no result, required one", i);
      end else begin
        checks++;
        if ({last_data, last_sum, last_ab, last_cd, last_tag} != {vecs[i].dout, vecs[i].sum, vecs[i].ab, vecs[i].cd, TAG_W'(i + 1)}) begin
          errors++;
          $display("FAIL vec%0d din=%0h: got data=%0h sum=%0h ab=%0b cd=%0b tag=%0h, required data=%0h sum=%0h ab=%0b cd=%0b tag=%0h",
                   i, vecs[i].din, last_data, last_sum, last_ab, last_cd, last_tag,
                   vecs[i].dout, vecs[i].sum, vecs[i].ab, vecs[i].cd, i + 1);
        end
        check("latency", last_out_cyc - last_in_cyc, 2);
      end
    end

    // All 16 operands back-to-back.
    n0 = n_out; c0 = cyc; acc = n_in;
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), TAG_W'(i), 1'b1);
    check("stream_accepted", n_in - acc, 16);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, '0, 1'b1);
    check("stream_count", n_out - n0, 16);
    check("stream_last_cycle", last_out_cyc, c0 + 17);

    // Output stalled, input held valid: capacity then back-pressure, then drain.
    acc = n_in;
    for (int i = 0; i < 6; i++) step(1'b1, 4'(4'h7 + i), TAG_W'(8 + i), 1'b0);
    check("stall_capacity", n_in - acc, CAP);
    check("stall_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'h0, '0, 1'b1);
    check("stall_drained", sb.size(), 0);

    // Reset with two results in flight.
    step(1'b1, 4'h6, TAG_W'(3), 1'b0);
    step(1'b1, 4'h9, TAG_W'(5), 1'b0);
    hold_chk = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", int'(out_valid), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, '0, 1'b1);
      check("post_reset_idle", int'(out_valid), 0);
    end

    // Random flow control against the scoreboard.
    for (int i = 0; i < 10000; i++)
      step(($urandom % 4) != 0, 4'($urandom), TAG_W'($urandom), ($urandom % 3) != 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 4'h0, '0, 1'b1);
    check("random_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
